ring_monitor: RTL and testbench

Receive-side checker and decoder for the one-hot ring-counter bus. Each enabled cycle it samples a `WIDTH`-bit ring code and validates it as one-hot. It then checks that the code follows the counter's right-rotate sequence (0001 → 1000 → 0100 → 0010 → 0001), decodes it to a binary index, and reports lock status and error events to the consuming logic.

---
 rtl/ring_monitor.sv | 137 +++++++++++++
 tb/tb_ring_monitor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ring_monitor.sv
// Receive-side checker/decoder for the one-hot ring-counter bus.
// Validates one-hot, tracks the right-rotate sequence, decodes the index and reports lock/errors.
//
// state   | meaning
// --------+-----------------------------------------------------------
// HUNT    | no valid reference code; next one-hot sample becomes prev
// TRACK   | reference held, counting consecutive good rotation steps
// LOCK    | LOCK_N consecutive steps seen; holds and steps keep lock
module ring_monitor #(
   parameter int WIDTH  = 4,
   parameter int LOCK_N = 4,
   localparam int IW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] ring_in,
   output logic [IW-1:0]    idx,
   output logic             idx_vld,
   output logic             onehot_err,
   output logic             seq_err,
   output logic             locked,
   output logic [7:0]       err_cnt
);

   localparam int CW = $clog2(LOCK_N + 1);

   localparam logic [1:0] ST_HUNT  = 2'd0;
   localparam logic [1:0] ST_TRACK = 2'd1;
   localparam logic [1:0] ST_LOCK  = 2'd2;

   logic [1:0]       state, state_nxt;
   logic [WIDTH-1:0] prev, prev_nxt;
   logic [CW-1:0]    good_cnt, good_nxt;
   logic             vld_nxt, oh_nxt, sq_nxt;

   logic [WIDTH-1:0] rot_prev;
   logic [WIDTH-1:0] ring_dec;
   logic             is_onehot;
   logic             is_hold;
   logic             is_step;
   logic [IW-1:0]    enc;
   logic [CW-1:0]    good_inc;

   assign rot_prev  = {prev[0], prev[WIDTH-1:1]};
   assign ring_dec  = ring_in - {{(WIDTH-1){1'b0}}, 1'b1};
   // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
   assign is_onehot = (ring_in != '0) && ((ring_in & ring_dec) == '0);
   assign is_hold   = (ring_in == prev);
   assign is_step   = (ring_in == rot_prev);
   assign good_inc  = good_cnt + CW'(1);

   // OR-reduction encoder; only meaningful when the sample is one-hot.
   always_comb begin
      enc = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (ring_in[i]) enc = enc | IW'(i);
      end
   end

   always_comb begin
      state_nxt = state;
      prev_nxt  = prev;
      good_nxt  = good_cnt;
      vld_nxt   = 1'b0;
      oh_nxt    = 1'b0;
      sq_nxt    = 1'b0;
      if (en) begin
         if (!is_onehot) begin
            oh_nxt    = 1'b1;
            state_nxt = ST_HUNT;
            good_nxt  = '0;
         end else begin
            case (state)
               ST_HUNT: begin
                  prev_nxt  = ring_in;
                  good_nxt  = '0;
                  state_nxt = ST_TRACK;
                  vld_nxt   = 1'b1;
               end
               ST_TRACK: begin
                  vld_nxt = 1'b1;
                  if (is_hold) begin
                     prev_nxt = ring_in;
                  end else if (is_step) begin
                     prev_nxt = ring_in;
                     good_nxt = good_inc;
                     if (good_inc == CW'(LOCK_N)) state_nxt = ST_LOCK;
                  end else begin
                     sq_nxt   = 1'b1;
                     prev_nxt = ring_in;
                     good_nxt = '0;
                  end
               end
               ST_LOCK: begin
                  vld_nxt  = 1'b1;
                  prev_nxt = ring_in;
                  if (!is_hold && !is_step) begin
                     sq_nxt    = 1'b1;
                     good_nxt  = '0;
                     state_nxt = ST_TRACK;
                  end
               end
               default: begin
                  state_nxt = ST_HUNT;
                  good_nxt  = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_HUNT;
         prev       <= '0;
         good_cnt   <= '0;
         idx        <= '0;
         idx_vld    <= 1'b0;
         onehot_err <= 1'b0;
         seq_err    <= 1'b0;
         locked     <= 1'b0;
         err_cnt    <= 8'd0;
      end else begin
         state      <= state_nxt;
         prev       <= prev_nxt;
         good_cnt   <= good_nxt;
         idx_vld    <= vld_nxt;
         onehot_err <= oh_nxt;
         seq_err    <= sq_nxt;
         locked     <= (state_nxt == ST_LOCK);
         if (vld_nxt) idx <= enc;
         if ((oh_nxt || sq_nxt) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_ring_monitor.sv
// Self-checking bench for ring_monitor: directed scenarios plus randomized traffic
// compared against an index-level behavioural model of the ring protocol.
module tb_ring_monitor;

   localparam int WIDTH  = 4;
   localparam int LOCK_N = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [3:0] ring_in = 4'b0000;
   logic [1:0] idx;
   logic       idx_vld, onehot_err, seq_err, locked;
   logic [7:0] err_cnt;

   int n_pass = 0;
   int n_checks = 0;

   // Reference model state, expressed as ring positions and a streak length.
   bit have_ref;
   int ref_idx;
   int streak;
   bit m_locked, m_vld, m_oh, m_sq;
   int m_idx;
   int m_err;

   ring_monitor #(.WIDTH(WIDTH), .LOCK_N(LOCK_N)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .ring_in(ring_in),
      .idx(idx), .idx_vld(idx_vld), .onehot_err(onehot_err), .seq_err(seq_err),
      .locked(locked), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      have_ref = 0; ref_idx = 0; streak = 0;
      m_locked = 0; m_vld = 0; m_oh = 0; m_sq = 0;
      m_idx = 0; m_err = 0;
   endtask

   task automatic model_step(input bit e, input logic [3:0] code);
      int k;
      m_vld = 0; m_oh = 0; m_sq = 0;
      if (!e) return;
      if ($countones(code) != 1) begin
         m_oh = 1; have_ref = 0; streak = 0; m_locked = 0;
      end else begin
         k = $clog2(code);
         m_vld = 1;
         m_idx = k;
         if (!have_ref) begin
            have_ref = 1; ref_idx = k; streak = 0;
         end else if (k == ref_idx) begin
            // hold: nothing changes
         end else if (k == (ref_idx + WIDTH - 1) % WIDTH) begin
            ref_idx = k;
            if (!m_locked) begin
               streak++;
               if (streak == LOCK_N) m_locked = 1;
            end
         end else begin
            m_sq = 1; ref_idx = k; streak = 0; m_locked = 0;
         end
      end
      if (m_oh || m_sq) m_err = (m_err < 255) ? m_err + 1 : 255;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".idx"}, 32'(idx), 32'(m_idx));
      check({tag, ".idx_vld"}, 32'(idx_vld), 32'(m_vld));
      check({tag, ".onehot_err"}, 32'(onehot_err), 32'(m_oh));
      check({tag, ".seq_err"}, 32'(seq_err), 32'(m_sq));
      check({tag, ".locked"}, 32'(locked), 32'(m_locked));
      check({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
   endtask

   task automatic step(input string tag, input bit e, input logic [3:0] code);
      @(negedge clk);
      en = e;
      ring_in = code;
      @(posedge clk);
      #1;
      model_step(e, code);
      check_all(tag);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".idx"}, 32'(idx), 0);
      check({tag, ".idx_vld"}, 32'(idx_vld), 0);
      check({tag, ".onehot_err"}, 32'(onehot_err), 0);
      check({tag, ".seq_err"}, 32'(seq_err), 0);
      check({tag, ".locked"}, 32'(locked), 0);
      check({tag, ".err_cnt"}, 32'(err_cnt), 0);
   endtask

   initial begin
      logic [3:0] code;
      int r;
      model_reset();

      // Reset values, then release away from the clock edge.
      #12;
      check_reset_values("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Reset and hold, then four steps to lock.
      step("hold0", 1, 4'b0001);
      step("hold1", 1, 4'b0001);
      step("s1000", 1, 4'b1000);
      step("s0100", 1, 4'b0100);
      step("s0010", 1, 4'b0010);
      step("s0001", 1, 4'b0001);
      check("lock_after_4", 32'(locked), 1);
      check("idx_after_4", 32'(idx), 0);

      // Invalid codes while locked.
      step("inv0110", 1, 4'b0110);
      check("inv_unlock", 32'(locked), 0);
      step("inv0000", 1, 4'b0000);
      check("inv_errcnt", 32'(err_cnt), 2);
      check("inv_idx_hold", 32'(idx), 0);

      // Relock at 0001, then skip to 0100 and recover.
      step("re0001", 1, 4'b0001);
      step("re1000", 1, 4'b1000);
      step("re0100", 1, 4'b0100);
      step("re0010", 1, 4'b0010);
      step("re0001b", 1, 4'b0001);
      step("skip0100", 1, 4'b0100);
      check("skip_idx", 32'(idx), 2);
      check("skip_seq", 32'(seq_err), 1);
      step("rc0010", 1, 4'b0010);
      step("rc0001", 1, 4'b0001);
      step("rc1000", 1, 4'b1000);
      step("rc0100", 1, 4'b0100);
      check("relock", 32'(locked), 1);

      // Enable gating from LOCK at 1000.
      step("g0010", 1, 4'b0010);
      step("g0001", 1, 4'b0001);
      step("g1000", 1, 4'b1000);
      for (int i = 0; i < 5; i++) step("gate_off", 0, 4'b0111);
      step("gate_step", 1, 4'b0100);
      check("gate_idx", 32'(idx), 2);

      // Asynchronous reset mid-LOCK, observed before the next edge.
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_values("rst_mid");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst", 1, 4'b0010);
      check("post_rst_idx", 32'(idx), 1);

      // Randomized traffic: mostly steps, with holds, skips, invalids and gaps.
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         if (r < 55 && have_ref)      code = 4'(1 << ((ref_idx + WIDTH - 1) % WIDTH));
         else if (r < 70 && have_ref) code = 4'(1 << ref_idx);
         else if (r < 85)             code = 4'(1 << $urandom_range(0, WIDTH - 1));
         else                         code = 4'($urandom_range(0, 15));
         step("rand", ($urandom_range(0, 9) != 0), code);
      end

      // Saturation of the error counter.
      for (int i = 0; i < 300; i++) step("sat", 1, 4'b0011);
      check("sat_cnt", 32'(err_cnt), 255);
      check("sat_pulse", 32'(onehot_err), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
